regfile_scoreboard: RTL and testbench
=====================================

# regfile_scoreboard

Parametrised register file for the MIPS pipeline's decode stage. It has two asynchronous read ports and one synchronous write-back port, with an optional same-cycle write-to-read bypass and a hardwired-zero register 0. A per-register pending-write scoreboard lets the hazard unit stall decode until an in-flight producer has written back. The scoreboard can be flushed on a pipeline squash.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, register index width; register count is NUM_REGS = 2**ADDR_W
- ZERO_REG, 1, when 1 register 0 reads 0, ignores writes and is never pending
- BYPASS, 1, when 1 a write-back in the current cycle is forwarded to a matching read port and clears the matching busy flag combinationally

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- rs  in  ADDR_W  read port 1 index
- rt  in  ADDR_W  read port 2 index
- RD1  out  DATA_W  read data for rs
- RD2  out  DATA_W  read data for rt
- regwrite  in  1  write-back enable (MEM/WB)
- writebackreg  in  ADDR_W  write-back index
- data_towrite_memwb  in  DATA_W  write-back data
- issue_valid  in  1  an instruction leaving decode will write issue_reg
- issue_reg  in  ADDR_W  destination of the issuing instruction
- flush  in  1  clear all pending bits (pipeline squash)
- rs_busy  out  1  rs has an outstanding write
- rt_busy  out  1  rt has an outstanding write
- pend_any  out  1  OR of all pending bits

## Operation
- Storage consists of NUM_REGS words of DATA_W bits plus a NUM_REGS-bit pending vector.
- Reset (rst=0) asynchronously clears all words and all pending bits. While rst=0, RD1, RD2, rs_busy, rt_busy and pend_any are all 0.
- Write: at a posedge with regwrite=1, the word at writebackreg is set to data_towrite_memwb. With ZERO_REG=1, a write to index 0 is dropped.
- Read is combinational:
  - If ZERO_REG=1 and the index is 0, the port reads 0.
  - Otherwise, if BYPASS=1, regwrite=1 and writebackreg equals the index, the port reads data_towrite_memwb.
  - Otherwise the port reads the stored word.
- Pending update at each posedge, in priority order:
  - flush=1: all bits cleared; a same-cycle issue is also discarded.
  - issue_valid=1: pending[issue_reg] is set, even if it is also being written back this cycle (the new producer wins).
  - regwrite=1: pending[writebackreg] is cleared, unless it was set by the rule above.
  - Issues and writes to index 0 never set a bit when ZERO_REG=1.
- Pending is a single bit per register. Two issues to the same register before write-back collapse into one, and the first write-back clears it. The pipeline guarantees in-order write-back, so this is sufficient.
- Busy is computed as rs_busy = pending[rs] AND NOT (BYPASS AND regwrite AND writebackreg==rs). rt_busy uses the same expression with rt.
- pend_any is the OR-reduction of the pending vector and is registered state only (no bypass term).

## Timing
- Read latency is 0 cycles. A written value is visible at the read port in the same cycle with BYPASS=1, and from the next cycle with BYPASS=0.
- issue_valid at edge N makes busy visible from edge N onward.
- Write-back in cycle N clears busy within cycle N with BYPASS=1, and from edge N+1 with BYPASS=0.
- flush takes effect at the next edge; busy outputs are 0 from then on.
- Reset asserted mid-operation clears state immediately, with no clock needed. Deassertion is synchronised externally. The first write is accepted at the first posedge after rst goes high.
- Out-of-range indices cannot occur, because the index width equals ADDR_W.

## Test plan
- Reset then read: pulse rst low, read rs=5, rt=31 -> RD1=0, RD2=0, rs_busy=rt_busy=0, pend_any=0.
- Write then read: write 0xDEADBEEF to r7 -> RD1 at rs=7 reads 0xDEADBEEF in the same cycle (BYPASS=1), or from the next cycle (BYPASS=0). A write of 0x1234 to r0 -> r0 still reads 0.
- Scoreboard: issue r9 at edge 1 -> rs=9 busy from edge 1. Write-back r9=0x55 in cycle 4 -> busy drops in cycle 4 (BYPASS=1) and RD1=0x55.
- Simultaneous events: in the same cycle, issue r3 and write back r3=0xA -> RD reads 0xA, and r3 is still pending after the edge. Then flush -> pend_any=0 after the next edge.
- Collapse: issue r4 twice, then one write-back of r4 -> r4 is not busy afterwards.
- Reset mid-operation: with r2 pending and r2=0x77 stored, drop rst asynchronously between edges -> busy=0 and RD=0 immediately. After release, r2 reads 0.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// Decode-stage register file: two combinational read ports, one write-back port,
// optional write-to-read bypass, hardwired-zero r0 and a per-register pending-write scoreboard.
module regfile_scoreboard #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rs,
    input  logic [ADDR_W-1:0] rt,
    output logic [DATA_W-1:0] RD1,
    output logic [DATA_W-1:0] RD2,
    input  logic              regwrite,
    input  logic [ADDR_W-1:0] writebackreg,
    input  logic [DATA_W-1:0] data_towrite_memwb,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_reg,
    input  logic              flush,
    output logic              rs_busy,
    output logic              rt_busy,
    output logic              pend_any
);

    localparam int NUM_REGS = 2 ** ADDR_W;
    localparam bit ZERO_EN  = (ZERO_REG != 0);
    localparam bit BYP_EN   = (BYPASS != 0);

    logic [DATA_W-1:0]   r_regs [NUM_REGS];
    logic [NUM_REGS-1:0] r_pending;

    logic                w_wr_en;
    logic                w_issue_en;
    logic [NUM_REGS-1:0] w_pending_next;
    logic [DATA_W-1:0]   w_rd1;
    logic [DATA_W-1:0]   w_rd2;
    logic                w_rs_fwd;
    logic                w_rt_fwd;

    // Writes and issues targeting a hardwired-zero r0 are dropped up front.
    assign w_wr_en    = regwrite    && !(ZERO_EN && (writebackreg == '0));
    assign w_issue_en = issue_valid && !(ZERO_EN && (issue_reg == '0));

    // NOTE: the register array is cleared on reset because the block guarantees
    // zero read data after reset; a memory macro without reset could not do this.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_regs[writebackreg] <= data_towrite_memwb;
        end
    end

    // Clear for the write-back first, then set for the issue, so a new producer
    // issued in the same cycle as the old one's write-back keeps the bit.
    // NOTE: combinational blocks use blocking assignments and start from a full
    // default, so later statements override earlier ones and no latch is inferred.
    always_comb begin
        w_pending_next = r_pending;
        if (flush) begin
            w_pending_next = '0;
        end else begin
            if (w_wr_en) begin
                w_pending_next[writebackreg] = 1'b0;
            end
            if (w_issue_en) begin
                w_pending_next[issue_reg] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_pending_next;
        end
    end

    assign w_rs_fwd = BYP_EN && regwrite && (writebackreg == rs);
    assign w_rt_fwd = BYP_EN && regwrite && (writebackreg == rt);

    always_comb begin
        w_rd1 = r_regs[rs];
        if (ZERO_EN && (rs == '0)) begin
            w_rd1 = '0;
        end else if (w_rs_fwd) begin
            w_rd1 = data_towrite_memwb;
        end
    end

    always_comb begin
        w_rd2 = r_regs[rt];
        if (ZERO_EN && (rt == '0)) begin
            w_rd2 = '0;
        end else if (w_rt_fwd) begin
            w_rd2 = data_towrite_memwb;
        end
    end

    // Outputs are forced low while reset is held so the bypass path cannot leak data.
    assign RD1      = rst ? w_rd1 : '0;
    assign RD2      = rst ? w_rd2 : '0;
    assign rs_busy  = rst && r_pending[rs] && !w_rs_fwd;
    assign rt_busy  = rst && r_pending[rt] && !w_rt_fwd;
    assign pend_any = rst && (|r_pending);

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Randomised scoreboard bench for regfile_scoreboard: a driver pushes expected read
// results from an array-based reference model, a negedge monitor pops and compares.
module tb_regfile_scoreboard;

    localparam int  DW    = 32;
    localparam int  AW    = 5;
    localparam int  NREGS = 32;
    localparam bit  ZR    = 1'b1;
    localparam bit  BYP   = 1'b1;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] rs, rt, writebackreg, issue_reg;
    logic [DW-1:0] RD1, RD2, data_towrite_memwb;
    logic          regwrite, issue_valid, flush;
    logic          rs_busy, rt_busy, pend_any;

    regfile_scoreboard #(
        .DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1), .BYPASS(1)
    ) dut (
        .clk(clk), .rst(rst), .rs(rs), .rt(rt), .RD1(RD1), .RD2(RD2),
        .regwrite(regwrite), .writebackreg(writebackreg),
        .data_towrite_memwb(data_towrite_memwb),
        .issue_valid(issue_valid), .issue_reg(issue_reg), .flush(flush),
        .rs_busy(rs_busy), .rt_busy(rt_busy), .pend_any(pend_any)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] rd1;
        logic [DW-1:0] rd2;
        logic          rsb;
        logic          rtb;
        logic          pany;
        int            cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    // Reference model: architectural contents and the set of registers awaiting write-back.
    logic [DW-1:0] m_mem  [NREGS];
    bit            m_pend [NREGS];

    task automatic check(input string name, input int c, input logic [DW-1:0] act,
                         input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, c, act, exp);
        end
    endtask

    exp_t m_e;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            m_e = exp_q.pop_front();
            check("RD1",      m_e.cyc, RD1, m_e.rd1);
            check("RD2",      m_e.cyc, RD2, m_e.rd2);
            check("rs_busy",  m_e.cyc, {31'b0, rs_busy},  {31'b0, m_e.rsb});
            check("rt_busy",  m_e.cyc, {31'b0, rt_busy},  {31'b0, m_e.rtb});
            check("pend_any", m_e.cyc, {31'b0, pend_any}, {31'b0, m_e.pany});
        end
    end

    function automatic logic [DW-1:0] m_read(input int idx, input logic we, input int wr,
                                             input logic [DW-1:0] wd);
        if (ZR && idx == 0) return '0;
        if (BYP && we && wr == idx) return wd;
        return m_mem[idx];
    endfunction

    function automatic logic m_busy(input int idx, input logic we, input int wr);
        return m_pend[idx] && !(BYP && we && wr == idx);
    endfunction

    function automatic logic m_any();
        foreach (m_pend[i]) if (m_pend[i]) return 1'b1;
        return 1'b0;
    endfunction

    // Apply one cycle of inputs just after a rising edge, predict the outputs seen
    // before the next edge, then advance the model across that edge.
    task automatic drive(input logic rstv, input int a, input int b, input logic we,
                         input int wr, input logic [DW-1:0] wd, input logic iv,
                         input int ir, input logic fl);
        exp_t e;
        rst = rstv; rs = AW'(a); rt = AW'(b);
        regwrite = we; writebackreg = AW'(wr); data_towrite_memwb = wd;
        issue_valid = iv; issue_reg = AW'(ir); flush = fl;
        if (!rstv) begin
            foreach (m_mem[i]) begin
                m_mem[i]  = '0;
                m_pend[i] = 1'b0;
            end
            e = '{rd1: '0, rd2: '0, rsb: 1'b0, rtb: 1'b0, pany: 1'b0, cyc: cyc};
        end else begin
            e.rd1  = m_read(a, we, wr, wd);
            e.rd2  = m_read(b, we, wr, wd);
            e.rsb  = m_busy(a, we, wr);
            e.rtb  = m_busy(b, we, wr);
            e.pany = m_any();
            e.cyc  = cyc;
        end
        exp_q.push_back(e);
        @(posedge clk);
        if (rstv) begin
            if (we && !(ZR && wr == 0)) m_mem[wr] = wd;
            if (fl) begin
                foreach (m_pend[i]) m_pend[i] = 1'b0;
            end else begin
                if (we) m_pend[wr] = 1'b0;
                if (iv && !(ZR && ir == 0)) m_pend[ir] = 1'b1;
            end
        end
        cyc++;
        #1;
    endtask

    function automatic int rand_idx();
        return ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NREGS - 1))
                                           : int'($urandom_range(0, 7));
    endfunction

    initial begin
        rst = 1'b0; rs = '0; rt = '0; regwrite = 1'b0; writebackreg = '0;
        data_towrite_memwb = '0; issue_valid = 1'b0; issue_reg = '0; flush = 1'b0;
        @(posedge clk);
        #1;
        // Reset state
        drive(0, 5, 31, 0, 0, 0, 0, 0, 0);
        // Write r7 with same-cycle bypass, then stored read; r0 ignores writes
        drive(1, 7, 0, 1, 7, 32'hDEADBEEF, 0, 0, 0);
        drive(1, 7, 7, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 7, 1, 0, 32'h1234, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 1, 0, 0);
        // Scoreboard: issue r9, hold busy, write-back clears it in-cycle
        drive(1, 9, 9, 0, 0, 0, 1, 9, 0);
        drive(1, 9, 1, 0, 0, 0, 0, 0, 0);
        drive(1, 9, 9, 0, 0, 0, 0, 0, 0);
        drive(1, 9, 9, 1, 9, 32'h55, 0, 0, 0);
        drive(1, 9, 9, 0, 0, 0, 0, 0, 0);
        // Same-cycle issue and write-back of r3, then flush
        drive(1, 3, 3, 1, 3, 32'hA, 1, 3, 0);
        drive(1, 3, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 3, 3, 0, 0, 0, 1, 6, 1);
        drive(1, 3, 6, 0, 0, 0, 0, 0, 0);
        // Collapse: two issues of r4, one write-back
        drive(1, 4, 4, 0, 0, 0, 1, 4, 0);
        drive(1, 4, 4, 0, 0, 0, 1, 4, 0);
        drive(1, 4, 4, 1, 4, 32'h44, 0, 0, 0);
        drive(1, 4, 4, 0, 0, 0, 0, 0, 0);
        // Reset mid-operation with r2 stored and pending, and a live bypass
        drive(1, 2, 2, 1, 2, 32'h77, 0, 0, 0);
        drive(1, 2, 2, 0, 0, 0, 1, 2, 0);
        drive(1, 2, 2, 0, 0, 0, 0, 0, 0);
        drive(0, 2, 2, 1, 2, 32'h99, 1, 2, 0);
        drive(1, 2, 2, 0, 0, 0, 0, 0, 0);
        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 199) != 0),
                  rand_idx(), rand_idx(),
                  ($urandom_range(0, 1) == 1), rand_idx(), $urandom(),
                  ($urandom_range(0, 2) == 0), rand_idx(),
                  ($urandom_range(0, 19) == 0));
        end
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expected entries never compared, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
